nibbler_uart_out: RTL
=====================

Name: nibbler_uart_out

Overview:
Output-port consumer for the Nibbler core. It captures each nibble the CPU writes with its active-low output-load strobe and buffers it in a small FIFO. Each nibble is converted to an ASCII hex character and transmitted as an 8N1 UART frame. It sits directly downstream of the CPU top and connects to its accumulator/ALU data bus and notLoadOut strobe.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit (>=2).
FIFO_DEPTH, 8, FIFO entries of 4 bits; power of 2, >=2.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
notLoadOut  in  1  active-low output-load strobe from the CPU.
data_in  in  4  nibble driven by the CPU while the strobe is low.
clr_ovf  in  1  synchronous clear of the overflow flag.
tx  out  1  UART serial line; idles high.
busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.
fifo_full  out  1  fifo_count == FIFO_DEPTH.
overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset (async, immediate):
  - tx=1, busy=0, fifo_count=0, fifo_full=0, overflow=0.
  - FSM=IDLE; strobe history register=1; FIFO pointers=0.
  - Any frame in progress is aborted and all FIFO contents are discarded.
- Strobe capture: falling-edge detect on notLoadOut. A push occurs at edge E when notLoadOut is 0 at E and was 1 at E-1. Holding the strobe low for N cycles produces exactly one push. data_in is sampled at E.
- FIFO:
  - Circular buffer with write/read pointers of width $clog2(FIFO_DEPTH); pointers wrap to 0.
  - A push when full is dropped and sets overflow=1.
  - A push and a pop in the same cycle are both performed, including when full; in that case the push is not dropped and fifo_count is unchanged.
  - clr_ovf=1 clears overflow at the next edge. If an overflow event occurs in the same cycle, the set wins.
- Character map:
  - 0x0-0x9 -> 0x30-0x39 ('0'-'9').
  - 0xA-0xF -> 0x41-0x46 ('A'-'F').
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head, load the 8-bit shift register with the ASCII value, clear the bit-timer, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - tx is registered.
  - A push at edge E into an empty FIFO with FSM in IDLE gives a pop at E+1, and tx falls at E+1.
  - A frame lasts 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly 1 IDLE cycle (tx=1) between the end of STOP and the next start bit.
- busy deasserts in the cycle the FSM enters IDLE with the FIFO empty.
- X-free: no output depends on data_in except through sampled FIFO contents.

Test Plan:
1. Hold reset, then release; no strobe for 100 cycles -> tx=1, busy=0, fifo_count=0, overflow=0 throughout.
2. One strobe with data_in=4'hA -> tx falls 1 cycle after the push edge.
   - Frame bits (16 cycles each): 0, 1,0,0,0,0,0,1,0, 1 (0x41 LSB first).
   - busy=0 after 160 cycles.
3. Strobes for nibbles 0..7, one every 2 cycles -> fifo_count peaks at 7.
   - Decoded byte stream is 0x30..0x37 in order.
   - Inter-frame gap is 1 cycle; overflow stays 0.
4. Ten strobes for values 0..9, one every 2 cycles, FIFO_DEPTH=8 -> first pushed value popped immediately, next 8 fill the FIFO (fifo_full=1), 10th dropped.
   - overflow=1; transmitted characters are '0'-'8' only.
   - clr_ovf pulse -> overflow=0.
5. notLoadOut held low for 5 cycles with data_in=4'h3 -> exactly one push, one frame 0x33.
   - Then a push coinciding with a pop while full -> fifo_count unchanged and overflow stays 0.
6. Assert reset during DATA bit 3 of a frame with 3 entries queued -> tx=1 and fifo_count=0 immediately (asynchronous).
   - After release, no frame is emitted.

Source files
------------

// File: rtl/nibbler_uart_out.sv
// Nibbler output-port consumer: captures CPU nibbles on the notLoadOut falling
// edge, queues them, and sends each one as an ASCII hex character in an 8N1 UART frame.
module nibbler_uart_out #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          notLoadOut,
  input  logic [3:0]                    data_in,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow
);

  // state | meaning
  // IDLE  | line high; pops the FIFO head whenever one is available
  // START | start bit (tx=0) for one bit time
  // DATA  | eight data bits, LSB first, one bit time each
  // STOP  | stop bit (tx=1) for one bit time

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx_nx;

  logic          strobe_q;
  logic          push, pop, push_ok, ovf_set;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    head;
  logic [7:0]    head_ascii;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) strobe_q <= 1'b1;
    else       strobe_q <= notLoadOut;
  end

  assign push      = strobe_q & ~notLoadOut;
  assign pop       = (state == IDLE) && (fifo_count != '0);
  // A full FIFO still accepts a push when the same edge pops the head.
  assign push_ok   = push && (!fifo_full || pop);
  assign ovf_set   = push && fifo_full && !pop;
  assign fifo_full = (fifo_count == DEPTH_C);
  assign busy      = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  assign head       = mem[rd_ptr];
  assign head_ascii = (head <= 4'd9) ? {4'h3, head} : (8'h37 + {4'h0, head});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
      tx      <= tx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nx = START;
          timer_nx = T_LOAD;
          shift_nx = head_ascii;
        end
      end
      START: begin
        if (timer == '0) begin
          state_nx   = DATA;
          timer_nx   = T_LOAD;
          bit_idx_nx = '0;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      DATA: begin
        if (timer == '0) begin
          timer_nx = T_LOAD;
          shift_nx = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_idx_nx = bit_idx + 1'b1;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      STOP: begin
        if (timer == '0) state_nx = IDLE;
        else             timer_nx = timer - 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // tx is registered from the next state so the line changes on the state edge.
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

endmodule
